// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int unsigned DEF_NREQ      = 4;
    localparam int unsigned DEF_WIDTH     = 16;
    localparam int unsigned DEF_MAX_BURST = 8;

    // Requester id width; a single-bit id is kept even for degenerate sizes.
    function automatic int unsigned id_w(input int unsigned nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    // Beat counter must hold 0..MAX_BURST.
    function automatic int unsigned cnt_w(input int unsigned max_burst);
        return (max_burst > 1) ? $clog2(max_burst + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first set request at or above ptr, wrapping to index 0.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned NREQ = DEF_NREQ,
    localparam int unsigned ID_W = id_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic            found,
    output logic [ID_W-1:0] idx
);

    // Wrapped region first, then the region from ptr upward; the last hit wins, so
    // the lowest index at/above ptr takes priority over anything below ptr.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i] && (ID_W'(i) < ptr)) begin
                found = 1'b1;
                idx   = ID_W'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i] && (ID_W'(i) >= ptr)) begin
                found = 1'b1;
                idx   = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-granular round-robin arbiter sharing one synchronous-FIFO write port among NREQ producers.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned NREQ      = DEF_NREQ,
    parameter  int unsigned WIDTH     = DEF_WIDTH,
    parameter  int unsigned MAX_BURST = DEF_MAX_BURST,
    localparam int unsigned ID_W      = id_w(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    fifo_full,
    output logic                    fifo_w_en,
    output logic [WIDTH-1:0]        fifo_wdata,
    output logic                    grant_valid,
    output logic [ID_W-1:0]         grant_id,
    output logic                    trunc
);

    localparam int unsigned      CNT_W    = cnt_w(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [ID_W-1:0]  ID_MAX   = ID_W'(NREQ - 1);

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  owner_q, owner_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic             pick_found;
    logic [ID_W-1:0]  pick_idx;
    logic             own_valid;
    logic             own_last;
    logic [WIDTH-1:0] own_data;
    logic             acc;
    logic             leave;

    rr_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Owner's request lines.
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == ID_W'(i)) begin
                own_valid = req_valid[i];
                own_last  = req_last[i];
                own_data  = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Reset in the current cycle suppresses any acceptance so no write slips through.
    assign acc   = (state_q == BURST) && !rst && !fifo_full && own_valid;
    assign leave = acc && (own_last || (beat_cnt_q == CNT_LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BURST;
                    owner_d = pick_idx;
                end
            end
            BURST: begin
                if (leave) begin
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                    rr_ptr_d   = (owner_q == ID_MAX) ? '0 : owner_q + 1'b1;
                end else if (acc) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = '0;
        fifo_w_en   = 1'b0;
        fifo_wdata  = '0;
        grant_valid = 1'b0;
        grant_id    = '0;
        trunc       = 1'b0;
        if ((state_q == BURST) && !rst) begin
            grant_valid = 1'b1;
            grant_id    = owner_q;
            fifo_wdata  = own_data;
            fifo_w_en   = acc;
            trunc       = leave && !own_last;
            for (int i = 0; i < NREQ; i++) begin
                if (owner_q == ID_W'(i)) req_ready[i] = !fifo_full;
            end
        end
    end

endmodule
